// File: rtl/nnrv_pkg.sv
// Shared defaults, return-tracking state encoding and load width codes.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nnrv_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int STARVE_MAX_DEF = 4;

  // Which read return, if any, is due from the RAM in the next cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RET_IF = 2'd1,
    ST_RET_D  = 2'd2
  } arb_state_t;

  // Byte-lane mask patterns after normalising to lane 0.
  localparam logic [3:0] MW_BYTE = 4'b0001;
  localparam logic [3:0] MW_HALF = 4'b0011;
  localparam logic [3:0] MW_WORD = 4'b1111;

endpackage

// File: rtl/nnrv_load_align.sv
// Load alignment: shift the RAM word down to lane 0 and sign/zero-extend it.
// Latency: combinational.
// Backpressure: none; a pure function of its inputs.
module nnrv_load_align
  import nnrv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [3:0]      mask,
  input  logic            sign,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;
  logic [3:0]      mask_n;

  // Normalise the word and mask to lane 0, then pick the access width from the mask.
  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    mask_n  = mask >> addr_lo;
    result  = rdata;
    case (mask_n)
      MW_BYTE: result = {{(XLEN-8){sign & shifted[7]}}, shifted[7:0]};
      MW_HALF: result = {{(XLEN-16){sign & shifted[15]}}, shifted[15:0]};
      MW_WORD: result = shifted;
      // Unrecognised masks hand back the raw RAM word.
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/nnrv_mem_arb.sv
// Fetch/data arbiter in front of one single-port synchronous RAM, with load alignment.
// Latency: grant is combinational; read data returns exactly one cycle after the grant.
// Backpressure: requesters hold until ack; data wins unless fetch has starved STARVE_MAX grants.
module nnrv_mem_arb
  import nnrv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_req,
  input  logic [XLEN-1:0]       i_if_addr,
  output logic                  o_if_ack,
  output logic                  o_if_rvalid,
  output logic [XLEN-1:0]       o_if_rdata,
  input  logic                  i_d_rd_en,
  input  logic                  i_d_wr_en,
  input  logic [XLEN-1:0]       i_d_addr,
  input  logic [XLEN-1:0]       i_d_wdata,
  input  logic [3:0]            i_d_mask,
  input  logic                  i_d_sign,
  output logic                  o_d_ack,
  output logic                  o_d_rvalid,
  output logic [XLEN-1:0]       o_d_rdata,
  output logic                  o_ram_en,
  output logic [3:0]            o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [XLEN-1:0]       o_ram_wdata,
  input  logic [XLEN-1:0]       i_ram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  arb_state_t      state;
  logic [SW-1:0]   starve_cnt;
  logic [1:0]      sv_addr_lo;
  logic [3:0]      sv_mask;
  logic            sv_sign;

  logic            d_req;
  logic            starved;
  logic            if_grant;
  logic            d_grant;
  logic            ld_grant;
  logic [XLEN-1:0] ld_result;

  // Per-cycle arbitration; everything is held off while reset is asserted.
  always_comb begin
    d_req    = i_d_rd_en | i_d_wr_en;
    starved  = (starve_cnt == STARVE_SAT);
    if_grant = i_rst_n & i_if_req & (~d_req | starved);
    d_grant  = i_rst_n & d_req & ~if_grant;
    // A store wins over a simultaneous load request; only pure loads return data.
    ld_grant = d_grant & ~i_d_wr_en;
  end

  assign o_if_ack = if_grant;
  assign o_d_ack  = d_grant;

  // RAM command for whichever requester was granted; idle when nobody was.
  always_comb begin
    o_ram_en    = if_grant | d_grant;
    o_ram_we    = 4'b0000;
    o_ram_addr  = '0;
    o_ram_wdata = i_rst_n ? i_d_wdata : '0;
    if (if_grant) begin
      o_ram_addr = i_if_addr[ADDR_WIDTH+1:2];
    end else if (d_grant) begin
      o_ram_addr = i_d_addr[ADDR_WIDTH+1:2];
      o_ram_we   = i_d_wr_en ? i_d_mask : 4'b0000;
    end
  end

  // Return tracker: remember which read is coming back next cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else if (if_grant) begin
      state <= ST_RET_IF;
    end else if (ld_grant) begin
      state <= ST_RET_D;
    end else begin
      state <= ST_IDLE;
    end
  end

  // Starvation counter: counts data grants that overtook a waiting fetch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (if_grant || !i_if_req) begin
      starve_cnt <= '0;
    end else if (d_grant && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Capture the alignment controls of a granted load for use on its return.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sv_addr_lo <= 2'b00;
      sv_mask    <= 4'b0000;
      sv_sign    <= 1'b0;
    end else if (ld_grant) begin
      sv_addr_lo <= i_d_addr[1:0];
      sv_mask    <= i_d_mask;
      sv_sign    <= i_d_sign;
    end
  end

  nnrv_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata  (i_ram_rdata),
    .addr_lo(sv_addr_lo),
    .mask   (sv_mask),
    .sign   (sv_sign),
    .result (ld_result)
  );

  // Returns are suppressed while reset is low so a pending read is discarded.
  always_comb begin
    o_if_rvalid = (state == ST_RET_IF) & i_rst_n;
    o_d_rvalid  = (state == ST_RET_D) & i_rst_n;
    o_if_rdata  = o_if_rvalid ? i_ram_rdata : '0;
    o_d_rdata   = o_d_rvalid ? ld_result : '0;
  end

  // Address bits outside the RAM word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_if_addr[XLEN-1:ADDR_WIDTH+2], i_if_addr[1:0],
                              i_d_addr[XLEN-1:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_nnrv_mem_arb.sv
module tb_nnrv_mem_arb;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_rd_en, d_wr_en;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_mask;
  logic        d_sign;
  logic        d_ack, d_rvalid;
  logic [31:0] d_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int n_pass = 0;
  int n_total = 0;

  nnrv_mem_arb #(.XLEN(32), .ADDR_WIDTH(8), .STARVE_MAX(SMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_rd_en(d_rd_en), .i_d_wr_en(d_wr_en), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .i_d_mask(d_mask), .i_d_sign(d_sign), .o_d_ack(d_ack),
    .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with byte write enables.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      else for (int b = 0; b < 4; b++) if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference load result: pick the bytes named by the mask and extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int lo,
                                           input logic [3:0] m, input bit s);
    logic [31:0] v;
    int mw;
    v  = w >> (8 * lo);
    mw = int'(m) >> lo;
    if (mw == 1) begin
      v = v % 256;
      if (s && v >= 128) v = v - 256;
      return v;
    end
    if (mw == 3) begin
      v = v % 65536;
      if (s && v >= 32768) v = v - 65536;
      return v;
    end
    if (mw == 15) return v;
    return w;
  endfunction

  // Reference model state.
  int          m_starve = 0;
  bit          g_if, g_d;
  bit          cur_if = 0, cur_d = 0, nx_if = 0, nx_d = 0;
  logic [31:0] cur_if_val = 0, cur_d_val = 0, nx_if_val = 0, nx_d_val = 0;

  // Check this cycle's outputs against the model (run mid-cycle).
  task automatic model_check();
    bit dreq, store;
    chk("if_rvalid", if_rvalid, (cur_if && rst_n));
    chk("if_rdata", if_rdata, (cur_if && rst_n) ? cur_if_val : 32'h0);
    chk("d_rvalid", d_rvalid, (cur_d && rst_n));
    chk("d_rdata", d_rdata, (cur_d && rst_n) ? cur_d_val : 32'h0);
    dreq  = d_rd_en || d_wr_en;
    store = d_wr_en;
    g_if  = rst_n && if_req && (!dreq || m_starve == SMAX);
    g_d   = rst_n && dreq && !g_if;
    chk("if_ack", if_ack, g_if);
    chk("d_ack", d_ack, g_d);
    chk("ram_en", ram_en, g_if || g_d);
    nx_if = 0;
    nx_d  = 0;
    if (g_if) begin
      chk("ram_addr_if", ram_addr, if_addr[9:2]);
      chk("ram_we_if", ram_we, 4'b0000);
      nx_if     = 1;
      nx_if_val = mem[if_addr[9:2]];
    end
    if (g_d) begin
      chk("ram_addr_d", ram_addr, d_addr[9:2]);
      chk("ram_we_d", ram_we, store ? d_mask : 4'b0000);
      if (store) chk("ram_wdata", ram_wdata, d_wdata);
      else begin
        nx_d     = 1;
        nx_d_val = ref_load(mem[d_addr[9:2]], int'(d_addr[1:0]), d_mask, d_sign);
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    model_check();
  endtask

  task automatic pos();
    @(posedge clk);
    if (!rst_n) m_starve = 0;
    else if (g_if || !if_req) m_starve = 0;
    else if (g_d && m_starve < SMAX) m_starve++;
    cur_if = nx_if; cur_if_val = nx_if_val;
    cur_d  = nx_d;  cur_d_val  = nx_d_val;
    #1;
  endtask

  task automatic idle();
    if_req = 0; if_addr = 0;
    d_rd_en = 0; d_wr_en = 0; d_addr = 0; d_wdata = 0; d_mask = 0; d_sign = 0;
  endtask

  initial begin
    int lo, kind, r;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    idle();
    rst_n = 0;
    repeat (3) begin neg(); pos(); end
    rst_n = 1;
    neg(); pos();

    // Fetch of 0x10 returning 0xDEADBEEF.
    mem[4] = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h10;
    neg();
    chk("fetch_ack", if_ack, 1);
    chk("fetch_ram_addr", ram_addr, 4);
    pos();
    idle();
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);

    // Signed and unsigned byte load from lane 3.
    mem[4] = 32'h80FF0000;
    for (int s = 1; s >= 0; s--) begin
      d_rd_en = 1; d_addr = 32'h13; d_mask = 4'b1000; d_sign = s[0];
      neg();
      chk("ldb_ack", d_ack, 1);
      pos();
      idle();
      chk("ldb_rdata", d_rdata, s ? 32'hFFFFFF80 : 32'h00000080);
    end

    // Upper-half store, then read it back as an unsigned half.
    d_wr_en = 1; d_addr = 32'h22; d_mask = 4'b1100; d_wdata = 32'hABCD0000;
    neg();
    chk("st_we", ram_we, 4'b1100);
    chk("st_addr", ram_addr, 8);
    pos();
    idle();
    chk("st_no_rvalid", d_rvalid, 0);
    d_rd_en = 1; d_addr = 32'h22; d_mask = 4'b1100; d_sign = 0;
    neg(); pos();
    idle();
    chk("st_readback", d_rdata, 32'h0000ABCD);
    neg(); pos();

    // Sustained contention: four data grants, then fetch.
    if_req = 1; if_addr = 32'h40;
    d_rd_en = 1; d_addr = 32'h10; d_mask = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      neg();
      chk("arb_seq", {if_ack, d_ack}, (k % 5 == 4) ? 2'b10 : 2'b01);
      pos();
    end
    idle();
    neg(); pos();

    // Reset the cycle after a load grant discards the return.
    d_rd_en = 1; d_addr = 32'h10; d_mask = 4'b1111;
    neg(); pos();
    rst_n = 0; idle();
    neg();
    chk("rst_drop_rvalid", d_rvalid, 0);
    pos();
    rst_n = 1;
    if_req = 1; if_addr = 32'h44;
    d_rd_en = 1; d_addr = 32'h18; d_mask = 4'b1111;
    neg();
    chk("post_rst_d_ack", d_ack, 1);
    chk("post_rst_if_ack", if_ack, 0);
    pos();
    idle();
    chk("post_rst_rvalid", d_rvalid, 1);
    neg(); pos();

    // Load and store both asserted: store only.
    d_rd_en = 1; d_wr_en = 1; d_addr = 32'h30; d_mask = 4'b0011; d_wdata = 32'h00001234;
    neg();
    chk("both_we", ram_we, 4'b0011);
    chk("both_ack", d_ack, 1);
    pos();
    idle();
    chk("both_no_rvalid", d_rvalid, 0);
    neg(); pos();

    // Randomised traffic with held requests and occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom % 50) != 0;
      if (!if_req || g_if) begin
        if_req  = ($urandom % 3) != 0;
        if_addr = ($urandom & 32'hFFFFFC00) | (($urandom % 256) << 2);
      end
      if (!(d_rd_en || d_wr_en) || g_d) begin
        lo   = $urandom % 4;
        kind = $urandom % 4;
        case (kind)
          0: d_mask = 4'b0001 << lo;
          1: begin lo = lo & 2; d_mask = 4'b0011 << lo; end
          2: begin lo = 0; d_mask = 4'b1111; end
          default: d_mask = 4'($urandom);
        endcase
        r = $urandom % 8;
        d_rd_en = (r >= 3 && r <= 5) || r == 7;
        d_wr_en = (r >= 6);
        d_addr  = ($urandom & 32'hFFFFFC00) | (($urandom % 256) << 2) | lo;
        d_wdata = $urandom;
        d_sign  = $urandom % 2;
      end
      neg(); pos();
    end
    rst_n = 1; idle();
    neg(); pos();
    neg();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nnrv_mem_arb.md
NNRV_MEM_ARB -- requirements
Module: nnrv_mem_arb

Interface
REQ-001 Parameters SHALL be: XLEN, 32, data width; ADDR_WIDTH, 8, RAM word-address width; STARVE_MAX, 4, consecutive data grants allowed while fetch waits.
REQ-002 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  in  1  reset; synchronous, active-low.
REQ-004 i_if_req  in  1  fetch read request, held with i_if_addr until o_if_ack.
REQ-005 i_if_addr  in  XLEN  fetch byte address, word-aligned.
REQ-006 o_if_ack  out  1  fetch request accepted this cycle.
REQ-007 o_if_rvalid / o_if_rdata  out  1 / XLEN  fetch word return.
REQ-008 i_d_rd_en / i_d_wr_en  in  1 / 1  data load / store request, held until o_d_ack.
REQ-009 i_d_addr / i_d_wdata  in  XLEN / XLEN  data byte address; store data already lane-shifted.
REQ-010 i_d_mask / i_d_sign  in  4 / 1  byte-lane mask already shifted by addr[1:0]; load sign-extend.
REQ-011 o_d_ack  out  1  data request accepted this cycle.
REQ-012 o_d_rvalid / o_d_rdata  out  1 / XLEN  aligned, extended load result.
REQ-013 o_ram_en / o_ram_we / o_ram_addr / o_ram_wdata  out  1 / 4 / ADDR_WIDTH / XLEN  single-port synchronous RAM command.
REQ-014 i_ram_rdata  in  XLEN  RAM read word, valid the cycle after a read command.

Function
REQ-015 Arbitration SHALL be combinational per cycle: at most one of o_if_ack, o_d_ack high; ack = grant = RAM command issued that cycle.
REQ-016 Priority: data over fetch, except when starve counter == STARVE_MAX and both request, fetch SHALL win.
REQ-017 Starve counter: +1 on each data grant while i_if_req high; cleared on fetch grant or when i_if_req low; saturates at STARVE_MAX.
REQ-018 i_d_rd_en and i_d_wr_en both high SHALL be treated as a store; the read is dropped.
REQ-019 RAM command: o_ram_addr = granted addr[ADDR_WIDTH+1:2]; o_ram_we = i_d_mask on store grant else 4'b0000; o_ram_wdata = i_d_wdata; o_ram_en = any grant.
REQ-020 FSM states IDLE, RET_IF, RET_D track the pending read return; next state = RET_IF on fetch grant, RET_D on load grant, else IDLE (stores return nothing).
REQ-021 Read latency exactly 1 cycle: o_*_rvalid high in the cycle after the grant, for one cycle; o_*_rdata driven from i_ram_rdata that cycle.
REQ-022 A new grant SHALL be allowed in RET_IF/RET_D (return overlaps next issue); back-to-back throughput one access per cycle.
REQ-023 Load alignment: registered addr[1:0], mask, sign; result = i_ram_rdata >> 8*addr[1:0]; width from mask >> addr[1:0]: 0001 byte, 0011 half, 1111 word.
REQ-024 Byte/half results SHALL sign-extend from bit 7/15 when sign=1, zero-extend when sign=0; other mask patterns SHALL return word unmodified.
REQ-025 Store ack cycle is completion; no store response.
REQ-026 o_if_rdata/o_d_rdata SHALL be zero when the matching rvalid is low.

Reset
REQ-027 While i_rst_n low at a clock edge: state IDLE, starve counter 0, saved align fields 0; o_*_rvalid 0 next cycle.
REQ-028 Reset during RET_IF/RET_D SHALL discard the pending return; no rvalid after release.
REQ-029 Acks and RAM command SHALL be forced low while i_rst_n is low.

Structure
REQ-030 Shared package nnrv_pkg SHALL hold XLEN, ADDR_WIDTH defaults, state encoding, mask-width codes.
REQ-031 Load align/extend logic SHALL be one sub-module nnrv_load_align (combinational: rdata, addr_lo, mask, sign -> result).

Verification
REQ-032 Fetch only, addr 0x10, RAM word 0xDEADBEEF -> o_if_ack cycle N, o_ram_addr 4, o_if_rvalid N+1, rdata 0xDEADBEEF.
REQ-033 Load byte addr 0x13, mask 1000, sign 1, RAM word 0x80FF_0000 -> o_d_rdata 0xFFFFFF80; sign 0 -> 0x00000080.
REQ-034 Store addr 0x22, mask 1100, wdata 0xABCD0000 -> o_ram_we 1100, o_ram_addr 8, no o_d_rvalid.
REQ-035 Fetch and load held high continuously -> grants D,D,D,D,IF repeating; counter resets after IF grant.
REQ-036 i_rst_n low the cycle after a load grant -> no o_d_rvalid; first grant after release behaves as from IDLE.
REQ-037 i_d_rd_en and i_d_wr_en both high -> store issued, o_ram_we = mask, no rvalid.
